// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - stall/flush sequencer for a 5-stage pipeline
// Merges ID-stage hazards with a data-cache miss handshake and counts frozen cycles.
module pipeline_stall_ctrl #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_hit_i,
  input  logic             dmem_ack_i,
  output logic             mem_req_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_write_o,
  output logic             memwb_write_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERR} state_e;

  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [WC_W-1:0]  WC_ONE    = WC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             err_q, err_d;
  logic             mem_req_q, mem_req_d;
  logic             miss;

  assign miss = dmem_req_i & ~dmem_hit_i;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    err_d         = err_q;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    exmem_write_o = 1'b0;
    memwb_write_o = 1'b0;
    case (state_q)
      S_RUN: begin
        if (miss) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = '0;
        end else if (branch_taken_i) begin
          pc_write_o    = 1'b1;
          ifid_write_o  = 1'b1;
          ifid_flush_o  = 1'b1;
          idex_bubble_o = 1'b1;
          exmem_write_o = 1'b1;
          memwb_write_o = 1'b1;
        end else if (load_use_i) begin
          idex_bubble_o = 1'b1;
          exmem_write_o = 1'b1;
          memwb_write_o = 1'b1;
        end else begin
          pc_write_o    = 1'b1;
          ifid_write_o  = 1'b1;
          exmem_write_o = 1'b1;
          memwb_write_o = 1'b1;
        end
      end
      // Whole pipe frozen; hazard inputs are irrelevant until the refill returns.
      S_MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_d = S_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_ONE;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  assign stall_cnt_d = (!pc_write_o && stall_cnt_q != CNT_MAX) ? stall_cnt_q + CNT_ONE
                                                               : stall_cnt_q;
  assign mem_req_d   = (state_d == S_MEM_WAIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed scoreboard bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  // ctl = {mem_req, pc, ifid, flush, bubble, exmem, memwb, err}
  localparam logic [7:0] C_IDLE = 8'b0110_0110;
  localparam logic [7:0] C_LU   = 8'b0000_1110;
  localparam logic [7:0] C_BR   = 8'b0111_1110;
  localparam logic [7:0] C_MISS = 8'b0000_0000;
  localparam logic [7:0] C_WAIT = 8'b1000_0000;
  localparam logic [7:0] C_ERR  = 8'b0000_0001;

  typedef struct {
    logic [7:0]       ctl;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_use = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0, dmem_hit = 1'b0, dmem_ack = 1'b0;
  logic mem_req, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_write, err;
  logic [CNT_W-1:0] stall_cnt;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .load_use_i(load_use), .branch_taken_i(branch_taken),
    .dmem_req_i(dmem_req), .dmem_hit_i(dmem_hit), .dmem_ack_i(dmem_ack),
    .mem_req_o(mem_req), .pc_write_o(pc_write), .ifid_write_o(ifid_write),
    .ifid_flush_o(ifid_flush), .idex_bubble_o(idex_bubble),
    .exmem_write_o(exmem_write), .memwb_write_o(memwb_write),
    .err_o(err), .stall_cnt_o(stall_cnt)
  );

  task automatic check_front();
    exp_t       e;
    logic [7:0] obs;
    n_cmp++;
    assert (sb_q.size() > 0) else begin
      n_bad++;
      $error("FAIL scoreboard_empty observed=0 expected>0");
    end
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = {mem_req, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_write, err};
      n_cmp++;
      assert (obs === e.ctl) else begin
        n_bad++;
        $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs, e.ctl);
      end
      n_cmp++;
      assert (stall_cnt === e.cnt) else begin
        n_bad++;
        $error("FAIL %s stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt, e.cnt);
      end
    end
  endtask

  // Called just after a falling edge; leaves just after the next falling edge.
  task automatic step(input logic lu, input logic br, input logic rq, input logic ht,
                      input logic ak, input logic [7:0] ctl, input int cnt, input string tag);
    exp_t e;
    load_use = lu; branch_taken = br; dmem_req = rq; dmem_hit = ht; dmem_ack = ak;
    e.ctl = ctl; e.cnt = CNT_W'(cnt); e.tag = tag;
    sb_q.push_back(e);
    #1;
    check_front();
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    load_use = 0; branch_taken = 0; dmem_req = 0; dmem_hit = 0; dmem_ack = 0;
    rst = 1'b1;
    e.ctl = C_IDLE; e.cnt = '0; e.tag = tag;
    sb_q.push_back(e);
    #1;
    check_front();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset("reset_initial");

    step(0, 0, 0, 0, 0, C_IDLE, 0, "idle_after_reset");
    step(1, 0, 0, 0, 0, C_LU,   0, "load_use");
    step(0, 0, 0, 0, 0, C_IDLE, 1, "after_load_use");
    step(1, 1, 0, 0, 0, C_BR,   1, "branch_over_load_use");
    step(0, 0, 0, 0, 0, C_IDLE, 1, "after_branch");
    step(0, 0, 1, 1, 0, C_IDLE, 1, "dmem_hit");
    step(0, 0, 0, 0, 1, C_IDLE, 1, "stray_ack_run");

    do_reset("reset_before_miss");
    step(0, 0, 1, 0, 0, C_MISS, 0, "miss_detect");
    step(1, 0, 0, 0, 0, C_WAIT, 1, "wait1_lu_ignored");
    step(0, 1, 0, 0, 0, C_WAIT, 2, "wait2_br_ignored");
    step(0, 0, 1, 0, 0, C_WAIT, 3, "wait3");
    step(0, 0, 0, 0, 0, C_WAIT, 4, "wait4");
    step(0, 0, 0, 0, 0, C_WAIT, 5, "wait5");
    step(0, 0, 0, 0, 1, C_WAIT, 6, "wait6_ack");
    step(0, 0, 1, 1, 0, C_IDLE, 7, "refill_replay_hit");
    step(0, 0, 0, 0, 0, C_IDLE, 7, "after_refill");

    do_reset("reset_before_timeout");
    step(0, 0, 1, 0, 0, C_MISS, 0, "to_miss_detect");
    for (int i = 1; i <= TIMEOUT; i++)
      step(0, 0, 0, 0, 0, C_WAIT, i, $sformatf("to_wait%0d", i));
    for (int i = 0; i < 9; i++)
      step(i[0], i[1], i[2], 1'b0, 1'b1, C_ERR, (TIMEOUT + 1 + i > 15) ? 15 : TIMEOUT + 1 + i,
           $sformatf("err_hold%0d", i));

    do_reset("reset_clears_err");
    step(0, 0, 1, 0, 0, C_MISS, 0, "mid_miss_detect");
    step(0, 0, 0, 0, 0, C_WAIT, 1, "mid_wait1");
    step(0, 0, 0, 0, 0, C_WAIT, 2, "mid_wait2");
    do_reset("reset_mid_wait");
    step(0, 0, 0, 0, 1, C_IDLE, 0, "stray_ack_after_reset");
    step(0, 0, 0, 0, 0, C_IDLE, 0, "idle_after_mid_reset");

    n_cmp++;
    assert (sb_q.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
